// File: rtl/zion_clr_vld_pipe_dff.sv
// ---------------------------------------------------------------------------
// zion_clr_vld_pipe_dff
//
// DEPTH-stage register pipeline with per-stage valid bits, a valid/ready
// handshake on both sides, bubble collapsing and a synchronous clear that
// reloads every data register with INI_DATA. Used to add registered latency
// between a producer and a consumer while still honouring backpressure, and
// to flush in-flight items on abort/redirect.
//
// Parameters
//   WIDTH_IN  : width of iDat (must equal WIDTH_OUT)
//   WIDTH_OUT : width of oDat
//   DEPTH     : number of register stages (>= 1)
//   INI_DATA  : data value loaded on reset (DAT_RST=1) and on clear
//   DAT_RST   : 1 = data registers async-reset to INI_DATA,
//               0 = data registers have no reset (valid bits always reset)
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   iClr : synchronous clear, active high; flushes every stage
//   iVld : upstream data valid
//   oRdy : ready to upstream (combinational from iRdy through the stages)
//   iDat : upstream data
//   oVld : downstream data valid (last stage, masked while clearing)
//   iRdy : ready from downstream; must not depend on oRdy
//   oDat : downstream data (last stage data register)
//   oCnt : number of occupied stages, 0..DEPTH
// ---------------------------------------------------------------------------
module zion_clr_vld_pipe_dff #(
    parameter int                   WIDTH_IN  = 8,
    parameter int                   WIDTH_OUT = 8,
    parameter int                   DEPTH     = 2,
    parameter logic [WIDTH_OUT-1:0] INI_DATA  = '0,
    parameter bit                   DAT_RST   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iClr,
    input  logic                         iVld,
    output logic                         oRdy,
    input  logic [WIDTH_IN-1:0]          iDat,
    output logic                         oVld,
    input  logic                         iRdy,
    output logic [WIDTH_OUT-1:0]         oDat,
    output logic [$clog2(DEPTH+1)-1:0]   oCnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // The pipeline never widens or narrows data, so a width mismatch or an
    // empty pipeline is a wiring mistake that must stop elaboration.
    generate
        if ((WIDTH_IN != WIDTH_OUT) || (DEPTH < 1)) begin : g_param_err
`ifdef CHECK_ERR_EXIT
            $fatal(1, "zion_clr_vld_pipe_dff: WIDTH_IN must equal WIDTH_OUT and DEPTH must be >= 1");
`else
            $error("zion_clr_vld_pipe_dff: WIDTH_IN must equal WIDTH_OUT and DEPTH must be >= 1");
`endif
        end
    endgenerate

    // Registered state: stage 0 is the input side, stage DEPTH-1 the output.
    logic [DEPTH-1:0]     vld_q;
    logic [WIDTH_OUT-1:0] dat_q [DEPTH];

    // Per-stage control derived from the current state.
    logic [DEPTH-1:0]     adv;     // stage content moves on this edge
    logic [DEPTH-1:0]     load;    // stage captures new content this edge
    logic                 rdy_in;  // stage 0 can take a new item
    logic [DEPTH-1:0]     vld_d;
    logic [DEPTH-1:0]     dat_en;
    logic [WIDTH_OUT-1:0] dat_d [DEPTH];

    // Ready chain, evaluated from the output towards the input. 'down' is
    // the "downstream of stage k has room" term; for the last stage it is
    // iRdy itself, for earlier stages it is an empty or advancing successor.
    // Keeping it in a local variable avoids a self-referencing adv vector.
    always_comb begin
        logic down;
        adv  = '0;
        down = iRdy;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k] = vld_q[k] & down;
            down   = ~vld_q[k] | adv[k];
        end
        rdy_in = down;
    end

    assign oRdy = ~iClr & rdy_in;

    // A stage loads when its feeder hands over (or, for stage 0, when the
    // upstream transfer happens). Clear overrides everything, including a
    // simultaneous push or pop.
    always_comb begin
        load    = '0;
        vld_d   = vld_q;
        dat_en  = '0;
        load[0] = iVld & oRdy;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = adv[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (iClr) begin
                vld_d[k]  = 1'b0;
                dat_en[k] = 1'b1;
            end else if (load[k]) begin
                vld_d[k]  = 1'b1;
                dat_en[k] = 1'b1;
            end else if (adv[k]) begin
                // Content left and nothing replaced it: stage becomes a
                // bubble, data register keeps its stale value.
                vld_d[k]  = 1'b0;
            end
        end
    end

    // Data source mux: clear value, upstream data, or the previous stage.
    always_comb begin
        dat_d[0] = iClr ? INI_DATA : iDat;
        for (int k = 1; k < DEPTH; k++) begin
            dat_d[k] = iClr ? INI_DATA : dat_q[k-1];
        end
    end

    // ---- stage registers: valid bits (always reset) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // ---- stage registers: data (reset optional) ----
    generate
        if (DAT_RST) begin : g_dat_rst
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        dat_q[k] <= INI_DATA;
                    end
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (dat_en[k]) begin
                            dat_q[k] <= dat_d[k];
                        end
                    end
                end
            end
        end else begin : g_dat_nrst
            always_ff @(posedge clk) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (dat_en[k]) begin
                        dat_q[k] <= dat_d[k];
                    end
                end
            end
        end
    endgenerate

    // Output side: valid is masked during clear so no transfer is counted
    // on the cycle the pipeline is being flushed.
    assign oVld = vld_q[DEPTH-1] & ~iClr;
    assign oDat = dat_q[DEPTH-1];

    // Occupancy from registered valid bits only.
    always_comb begin
        oCnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            oCnt = oCnt + CNT_W'(vld_q[k]);
        end
    end

endmodule

// File: tb/tb_zion_clr_vld_pipe_dff.sv
module tb_zion_clr_vld_pipe_dff;

    localparam int          W   = 8;
    localparam int          D   = 3;
    localparam logic [7:0]  INI = 8'hA5;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with data reset
    logic       rst, clr, vld, rdy, ordy, ovld;
    logic [7:0] dat, odat;
    logic [1:0] cnt;

    // DUT without data reset
    logic       rst_b, clr_b, vld_b, rdy_b, ordy_b, ovld_b;
    logic [7:0] dat_b, odat_b;
    logic [1:0] cnt_b;

    zion_clr_vld_pipe_dff #(
        .WIDTH_IN(W), .WIDTH_OUT(W), .DEPTH(D), .INI_DATA(INI), .DAT_RST(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .iClr(clr), .iVld(vld), .oRdy(ordy), .iDat(dat),
        .oVld(ovld), .iRdy(rdy), .oDat(odat), .oCnt(cnt)
    );

    zion_clr_vld_pipe_dff #(
        .WIDTH_IN(W), .WIDTH_OUT(W), .DEPTH(D), .INI_DATA(INI), .DAT_RST(1'b0)
    ) u_dut_nr (
        .clk(clk), .rst(rst_b), .iClr(clr_b), .iVld(vld_b), .oRdy(ordy_b), .iDat(dat_b),
        .oVld(ovld_b), .iRdy(rdy_b), .oDat(odat_b), .oCnt(cnt_b)
    );

    typedef struct {
        logic       rst;
        logic       clr;
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_dat;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic v, input logic [7:0] d,
                       input logic rd, input logic er, input logic ev, input logic [7:0] ed,
                       input logic [1:0] ec);
        vec_t t;
        t.rst = r; t.clr = c; t.vld = v; t.dat = d; t.rdy = rd;
        t.e_rdy = er; t.e_vld = ev; t.e_dat = ed; t.e_cnt = ec;
        tbl.push_back(t);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; vld = 1'b0; dat = '0; rdy = 1'b0;
        rst_b = 1'b0; clr_b = 1'b0; vld_b = 1'b0; dat_b = '0; rdy_b = 1'b0;

        //   rst clr vld dat    rdy  ordy ovld odat   cnt
        // reset and idle after release
        add(0, 0, 0, 8'h00, 0,   1, 0, 8'hA5, 0);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'hA5, 0);
        // streaming with iRdy=1
        add(1, 0, 1, 8'h01, 1,   1, 0, 8'hA5, 0);
        add(1, 0, 1, 8'h02, 1,   1, 0, 8'hA5, 1);
        add(1, 0, 1, 8'h03, 1,   1, 0, 8'hA5, 2);
        add(1, 0, 1, 8'h04, 1,   1, 1, 8'h01, 3);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h02, 3);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h03, 2);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h04, 1);
        add(1, 0, 0, 8'h00, 1,   1, 0, 8'h04, 0);
        // backpressure: fill, full stall, pass-through release
        add(1, 0, 1, 8'h10, 0,   1, 0, 8'h04, 0);
        add(1, 0, 1, 8'h11, 0,   1, 0, 8'h04, 1);
        add(1, 0, 1, 8'h12, 0,   1, 0, 8'h04, 2);
        add(1, 0, 1, 8'h13, 0,   0, 1, 8'h10, 3);
        add(1, 0, 1, 8'h13, 1,   1, 1, 8'h10, 3);
        add(1, 0, 1, 8'h14, 1,   1, 1, 8'h11, 3);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h12, 3);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h13, 2);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h14, 1);
        // bubble collapse with iRdy=0
        add(1, 0, 1, 8'h20, 0,   1, 0, 8'h14, 0);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h14, 1);
        add(1, 0, 0, 8'h00, 0,   1, 0, 8'h14, 1);
        add(1, 0, 1, 8'h21, 0,   1, 1, 8'h20, 1);
        add(1, 0, 0, 8'h00, 0,   1, 1, 8'h20, 2);
        add(1, 0, 0, 8'h00, 0,   1, 1, 8'h20, 2);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h20, 2);
        add(1, 0, 0, 8'h00, 1,   1, 1, 8'h21, 1);
        // clear a full pipe with a simultaneous push and pop
        add(1, 0, 1, 8'h30, 0,   1, 0, 8'h21, 0);
        add(1, 0, 1, 8'h31, 0,   1, 0, 8'h21, 1);
        add(1, 0, 1, 8'h32, 0,   1, 0, 8'h21, 2);
        add(1, 1, 1, 8'h33, 1,   0, 0, 8'h30, 3);
        add(1, 0, 0, 8'h00, 1,   1, 0, 8'hA5, 0);
        add(1, 0, 0, 8'h00, 1,   1, 0, 8'hA5, 0);
        // clear while empty
        add(1, 1, 1, 8'h44, 1,   0, 0, 8'hA5, 0);
        add(1, 0, 0, 8'h00, 1,   1, 0, 8'hA5, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; clr = tbl[i].clr; vld = tbl[i].vld;
            dat = tbl[i].dat; rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.oRdy", i), 32'(ordy), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.oVld", i), 32'(ovld), 32'(tbl[i].e_vld));
            chk($sformatf("v%0d.oDat", i), 32'(odat), 32'(tbl[i].e_dat));
            chk($sformatf("v%0d.oCnt", i), 32'(cnt),  32'(tbl[i].e_cnt));
            next_cycle();
        end

        // Async reset in the middle of a stream (data-reset instance)
        clr = 1'b0; rdy = 1'b0; vld = 1'b1;
        dat = 8'h50; next_cycle();
        dat = 8'h51; next_cycle();
        dat = 8'h52; next_cycle();
        vld = 1'b0;
        #2;
        chk("mid.full_vld", 32'(ovld), 32'd1);
        chk("mid.full_dat", 32'(odat), 32'h50);
        rst = 1'b0;
        #1;
        chk("mid.rst_vld", 32'(ovld), 32'd0);
        chk("mid.rst_cnt", 32'(cnt),  32'd0);
        chk("mid.rst_dat", 32'(odat), 32'hA5);
        chk("mid.rst_rdy", 32'(ordy), 32'd1);
        next_cycle();
        rst = 1'b1; rdy = 1'b1;
        next_cycle();
        #2;
        chk("mid.post_vld", 32'(ovld), 32'd0);
        chk("mid.post_cnt", 32'(cnt),  32'd0);

        // Instance without data reset: only valid bits are reset
        rst_b = 1'b1;
        #2;
        chk("nr.init_vld", 32'(ovld_b), 32'd0);
        chk("nr.init_cnt", 32'(cnt_b),  32'd0);
        next_cycle();
        vld_b = 1'b1;
        dat_b = 8'h60; next_cycle();
        dat_b = 8'h61; next_cycle();
        dat_b = 8'h62; next_cycle();
        vld_b = 1'b0;
        #2;
        chk("nr.full_vld", 32'(ovld_b), 32'd1);
        chk("nr.full_dat", 32'(odat_b), 32'h60);
        chk("nr.full_rdy", 32'(ordy_b), 32'd0);
        rst_b = 1'b0;
        #1;
        chk("nr.rst_vld", 32'(ovld_b), 32'd0);
        chk("nr.rst_cnt", 32'(cnt_b),  32'd0);
        chk("nr.rst_dat_kept", 32'(odat_b), 32'h60);
        next_cycle();
        rst_b = 1'b1; clr_b = 1'b1;
        next_cycle();
        clr_b = 1'b0;
        #2;
        chk("nr.clr_dat", 32'(odat_b), 32'hA5);
        chk("nr.clr_cnt", 32'(cnt_b),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
